mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Single-port memory controller between the pipeline and the byte-wide RAM/IO bus. It arbitrates between instruction fetch (IF) and the MEM stage, and splits each 1/2/4-byte load or store into sequential byte accesses. Loads are assembled into a little-endian 32-bit word, and completion is reported to the requester with a one-cycle done pulse. It sits between IF/MEM and the top-level RAM port.

## Interface
- No parameters; state encodings and length codes come from `define.v`.
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-high (`RstEnable` = 1)
- if_read  input  1  IF fetch request (level)
- if_addr  input  32  fetch address
- if_flush  input  1  branch/jump flush; aborts an IF fetch in flight
- if_done  output  1  one-cycle pulse; if_inst valid
- if_inst  output  32  fetched word
- read_mem  input  1  MEM load request (level)
- write_mem  input  1  MEM store request (level)
- mem_addr_to_read  input  32  load/store byte address
- mem_data_to_write  input  32  store data, byte 0 = bits [7:0]
- data_len  input  3  byte count: 1, 2 or 4
- mem_load_done  output  1  one-cycle pulse at end of a MEM load or store
- mem_ctrl_read_in  output  32  load data, zero-extended above data_len bytes
- mem_ctrl_busy_state  output  2  {MEM transaction active, IF transaction active}
- mem_din  input  8  RAM read data; valid one cycle after address
- mem_dout  output  8  RAM write data
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 = write, 0 = read

## Operation
- States: IDLE, IF_READ, MEM_READ, MEM_WRITE.
- IDLE, arbitration, evaluated each cycle:
  - write_mem, then read_mem (MEM has priority), then if_read.
  - Simultaneous read_mem and write_mem: write wins.
  - A request whose data_len is not 1/2/4 is not accepted.
  - if_read accompanied by if_flush is not accepted.
- At accept, the controller latches address, len (4 for IF), and write data. Requester inputs are ignored until the controller returns to IDLE.
- Byte counter `sent` (0..len) and receive counter `got` (0..len):
  - Byte k uses address base+k. Byte k of a store is data[8k+7:8k].
  - Read byte k lands in result[8k+7:8k]; upper bytes are cleared at accept.
- MEM stage clears its request when busy_state[1]=1 or done=1; the controller does not rely on the request being held.
- if_flush during IF_READ: go to IDLE at the next edge. No if_done; the in-flight RAM byte is discarded. if_flush has no effect on MEM states.
- Idle bus values: mem_a=0, mem_wr=0, mem_dout=0.
- Outputs are registered.
- Reset, including mid-transaction: state IDLE, counters 0, and all outputs 0, including if_inst, mem_ctrl_read_in, busy_state, and the done pulses. No done is produced for an aborted transaction.

## Timing
- Cycle 0 is the cycle in which a request is seen in IDLE.
- Read of n bytes:
  - mem_a = base+k in cycle 1+k, with mem_wr=0.
  - mem_din byte k is captured at the end of cycle 2+k.
  - The done pulse and data appear in cycle n+2. The state is IDLE in cycle n+2, so a new request can be accepted in that same cycle.
  - IF word fetch: if_done in cycle 6.
- Write of n bytes:
  - mem_a = base+k, mem_dout = byte k, and mem_wr=1 in cycle 1+k.
  - mem_load_done in cycle n+1; IDLE in cycle n+1.
- busy_state bit is high from cycle 1 until the cycle before done, and low in the done cycle.
- Done pulses are exactly one cycle wide and never asserted together.
- if_inst and mem_ctrl_read_in hold their value until the next completion of the same requester.

## Structure
- `define.v` holds:
  - State encodings: `MemIdle`, `MemIfRead`, `MemMemRead`, `MemMemWrite`.
  - Length constants: `Len1`, `Len2`, `Len4`.
  - The existing `RstEnable`/`True`/`False`.
- No sub-module:
  - one FSM sequential block with counters and latches;
  - one combinational block for next-address and next-byte selection.

## Test plan
- IF fetch, RAM[0x100..0x103]=13 05 00 00: if_read at cycle 0 -> mem_a 0x100..0x103 in cycles 1-4, if_done in cycle 6, if_inst=0x00000513.
- LB at 0x2000, RAM=0x80: read_mem, len 1 -> mem_load_done in cycle 3, read_in=0x00000080, busy_state=2'b10 in cycles 1-2.
- SW 0xDEADBEEF at 0x1000 -> mem_wr=1 with mem_dout EF, BE, AD, DE at 0x1000..0x1003 in cycles 1-4, done in cycle 5, then mem_wr=0.
- Simultaneous if_read and read_mem (len 2) -> MEM served first. IF is accepted in the MEM done cycle; if_done follows 6 cycles later.
- if_flush asserted in cycle 3 of an IF fetch -> IDLE next cycle, no if_done; a new fetch at 0x200 returns the correct word.
- rst_in asserted in cycle 2 of a 4-byte store -> next cycle all outputs 0, state IDLE, no done pulse, no further mem_wr.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
// State encodings and the legal transfer lengths live here.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE      = 2'd0,
        MEM_IF_READ   = 2'd1,
        MEM_MEM_READ  = 2'd2,
        MEM_MEM_WRITE = 2'd3
    } mem_state_e;

    localparam logic [2:0] LEN1 = 3'd1;
    localparam logic [2:0] LEN2 = 3'd2;
    localparam logic [2:0] LEN4 = 3'd4;

    function automatic logic len_ok(input logic [2:0] len);
        return (len == LEN1) || (len == LEN2) || (len == LEN4);
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Single-port byte-serial memory controller arbitrating IF fetches and MEM loads/stores.
// Each 1/2/4-byte access is split into sequential byte cycles; all outputs are registered.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        if_read,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic [31:0] mem_addr_to_read,
    input  logic [31:0] mem_data_to_write,
    input  logic [2:0]  data_len,
    output logic        mem_load_done,
    output logic [31:0] mem_ctrl_read_in,
    output logic [1:0]  mem_ctrl_busy_state,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    mem_state_e  state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  sent_q, sent_d;
    logic [2:0]  got_q, got_d;
    // issued: a read address is on the bus this cycle; din_vld: mem_din holds a requested byte
    logic        issued_q, issued_d;
    logic        din_vld_q, din_vld_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] read_in_q, read_in_d;
    logic [1:0]  busy_q, busy_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        result_d   = result_q;
        sent_d     = sent_q;
        got_d      = got_q;
        issued_d   = 1'b0;
        din_vld_d  = issued_q;
        if_done_d  = 1'b0;
        if_inst_d  = if_inst_q;
        mem_done_d = 1'b0;
        read_in_d  = read_in_q;
        mem_a_d    = '0;
        mem_dout_d = '0;
        mem_wr_d   = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                if (write_mem && len_ok(data_len)) begin
                    state_d    = MEM_MEM_WRITE;
                    base_d     = mem_addr_to_read;
                    len_d      = data_len;
                    wdata_d    = mem_data_to_write;
                    sent_d     = 3'd1;
                    got_d      = '0;
                    mem_a_d    = mem_addr_to_read;
                    mem_dout_d = mem_data_to_write[7:0];
                    mem_wr_d   = 1'b1;
                end else if (read_mem && len_ok(data_len)) begin
                    state_d  = MEM_MEM_READ;
                    base_d   = mem_addr_to_read;
                    len_d    = data_len;
                    result_d = '0;
                    sent_d   = 3'd1;
                    got_d    = '0;
                    mem_a_d  = mem_addr_to_read;
                    issued_d = 1'b1;
                end else if (if_read && !if_flush) begin
                    state_d  = MEM_IF_READ;
                    base_d   = if_addr;
                    len_d    = LEN4;
                    result_d = '0;
                    sent_d   = 3'd1;
                    got_d    = '0;
                    mem_a_d  = if_addr;
                    issued_d = 1'b1;
                end
            end

            MEM_MEM_WRITE: begin
                if (sent_q == len_q) begin
                    state_d    = MEM_IDLE;
                    mem_done_d = 1'b1;
                    sent_d     = '0;
                end else begin
                    mem_a_d    = base_q + {29'd0, sent_q};
                    mem_dout_d = get_byte(wdata_q, sent_q[1:0]);
                    mem_wr_d   = 1'b1;
                    sent_d     = sent_q + 3'd1;
                end
            end

            MEM_IF_READ, MEM_MEM_READ: begin
                if (state_q == MEM_IF_READ && if_flush) begin
                    // Abort: drop the byte still in flight and free the bus immediately
                    state_d   = MEM_IDLE;
                    sent_d    = '0;
                    got_d     = '0;
                    din_vld_d = 1'b0;
                end else begin
                    if (sent_q < len_q) begin
                        mem_a_d  = base_q + {29'd0, sent_q};
                        issued_d = 1'b1;
                        sent_d   = sent_q + 3'd1;
                    end
                    if (din_vld_q) begin
                        result_d[{got_q[1:0], 3'b000} +: 8] = mem_din;
                        got_d = got_q + 3'd1;
                        if (got_q + 3'd1 == len_q) begin
                            state_d = MEM_IDLE;
                            sent_d  = '0;
                            got_d   = '0;
                            if (state_q == MEM_IF_READ) begin
                                if_inst_d = result_d;
                                if_done_d = 1'b1;
                            end else begin
                                read_in_d  = result_d;
                                mem_done_d = 1'b1;
                            end
                        end
                    end
                end
            end
        endcase

        busy_d = {(state_d == MEM_MEM_READ) || (state_d == MEM_MEM_WRITE),
                  (state_d == MEM_IF_READ)};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= MEM_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            result_q   <= '0;
            sent_q     <= '0;
            got_q      <= '0;
            issued_q   <= 1'b0;
            din_vld_q  <= 1'b0;
            if_done_q  <= 1'b0;
            if_inst_q  <= '0;
            mem_done_q <= 1'b0;
            read_in_q  <= '0;
            busy_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            result_q   <= result_d;
            sent_q     <= sent_d;
            got_q      <= got_d;
            issued_q   <= issued_d;
            din_vld_q  <= din_vld_d;
            if_done_q  <= if_done_d;
            if_inst_q  <= if_inst_d;
            mem_done_q <= mem_done_d;
            read_in_q  <= read_in_d;
            busy_q     <= busy_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign if_done             = if_done_q;
    assign if_inst             = if_inst_q;
    assign mem_load_done       = mem_done_q;
    assign mem_ctrl_read_in    = read_in_q;
    assign mem_ctrl_busy_state = busy_q;
    assign mem_a               = mem_a_q;
    assign mem_dout            = mem_dout_q;
    assign mem_wr              = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM model on the bus, transaction-level
// expectations derived from the cycle-numbered timing rules and a reference byte memory.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        if_read, if_flush, read_mem, write_mem;
    logic [31:0] if_addr, mem_addr_to_read, mem_data_to_write;
    logic [2:0]  data_len;
    logic        if_done, mem_load_done, mem_wr;
    logic [31:0] if_inst, mem_ctrl_read_in, mem_a;
    logic [1:0]  mem_ctrl_busy_state;
    logic [7:0]  mem_din, mem_dout;

    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];
    int total = 0;
    int bad   = 0;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .if_read(if_read), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_inst(if_inst),
        .read_mem(read_mem), .write_mem(write_mem),
        .mem_addr_to_read(mem_addr_to_read), .mem_data_to_write(mem_data_to_write),
        .data_len(data_len), .mem_load_done(mem_load_done),
        .mem_ctrl_read_in(mem_ctrl_read_in), .mem_ctrl_busy_state(mem_ctrl_busy_state),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    // RAM: read data is valid the cycle after the address
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        mem_din <= ram[mem_a[15:0]];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            ram[addr[15:0] + 16'(k)]     = w[8*k +: 8];
            ref_mem[addr[15:0] + 16'(k)] = w[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr, input int n);
        logic [31:0] w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ref_mem[addr[15:0] + 16'(k)];
        return w;
    endfunction

    task automatic check_idle_outs(input string tag);
        chk({tag, ".mem_a"}, mem_a, 32'd0);
        chk({tag, ".mem_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({tag, ".busy"}, {30'd0, mem_ctrl_busy_state}, 32'd0);
        chk({tag, ".if_done"}, {31'd0, if_done}, 32'd0);
        chk({tag, ".mem_done"}, {31'd0, mem_load_done}, 32'd0);
    endtask

    // kind: 0 = IF fetch, 1 = MEM load, 2 = MEM store. Starts and ends just after a posedge.
    task automatic run_txn(input int kind, input logic [31:0] addr, input int n_in, input logic [31:0] wd);
        int nb, last;
        logic [31:0] exp_word;
        nb = (kind == 0) ? 4 : n_in;
        exp_word = ref_word(addr, nb);
        last = (kind == 2) ? nb + 1 : nb + 2;
        case (kind)
            0: begin if_addr = addr; if_read = 1'b1; end
            1: begin mem_addr_to_read = addr; data_len = 3'(nb); read_mem = 1'b1;
                     if_flush = 1'($urandom_range(0, 1)); end
            default: begin mem_addr_to_read = addr; data_len = 3'(nb); mem_data_to_write = wd;
                     write_mem = 1'b1; if_flush = 1'($urandom_range(0, 1)); end
        endcase
        for (int c = 1; c <= last + 1; c++) begin
            @(posedge clk_in); #1;
            if (c == 1) begin if_read = 0; read_mem = 0; write_mem = 0; end
            @(negedge clk_in);
            if (c <= nb) begin
                chk("bus.mem_a", mem_a, addr + 32'(c - 1));
                chk("bus.mem_wr", {31'd0, mem_wr}, {31'd0, kind == 2});
                if (kind == 2) chk("bus.mem_dout", {24'd0, mem_dout}, {24'd0, wd[8*(c-1) +: 8]});
            end else begin
                chk("bus.idle_a", mem_a, 32'd0);
                chk("bus.idle_wr", {31'd0, mem_wr}, 32'd0);
            end
            chk("busy", {30'd0, mem_ctrl_busy_state},
                (c < last) ? ((kind == 0) ? 32'd1 : 32'd2) : 32'd0);
            chk("if_done", {31'd0, if_done}, {31'd0, kind == 0 && c == last});
            chk("mem_done", {31'd0, mem_load_done}, {31'd0, kind != 0 && c == last});
            if (c >= last && kind == 0) chk("if_inst", if_inst, exp_word);
            if (c >= last && kind == 1) chk("read_in", mem_ctrl_read_in, exp_word);
        end
        if_flush = 1'b0;
        if (kind == 2)
            for (int k = 0; k < nb; k++) ref_mem[addr[15:0] + 16'(k)] = wd[8*k +: 8];
        @(posedge clk_in); #1;
    endtask

    // One-cycle request that must not be accepted.
    task automatic try_reject(input int kind);
        case (kind)
            0: begin if_addr = 32'h3100; if_read = 1'b1; if_flush = 1'b1; end
            1: begin mem_addr_to_read = 32'h3100; data_len = 3'd3; read_mem = 1'b1; end
            default: begin mem_addr_to_read = 32'h3100; data_len = 3'd0; write_mem = 1'b1; end
        endcase
        @(posedge clk_in); #1;
        if_read = 0; read_mem = 0; write_mem = 0; if_flush = 0;
        @(negedge clk_in);
        check_idle_outs("reject");
        @(posedge clk_in); #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        rst_in = 1; if_read = 0; if_flush = 0; read_mem = 0; write_mem = 0;
        if_addr = 0; mem_addr_to_read = 0; mem_data_to_write = 0; data_len = 0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check_idle_outs("reset");
        chk("reset.if_inst", if_inst, 32'd0);
        chk("reset.read_in", mem_ctrl_read_in, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 0;
        @(posedge clk_in); #1;

        preload(32'h100, 32'h00000513, 4);
        run_txn(0, 32'h100, 4, 0);
        preload(32'h2000, 32'h00001280, 2);
        run_txn(1, 32'h2000, 1, 0);
        run_txn(2, 32'h1000, 4, 32'hDEADBEEF);
        run_txn(1, 32'h1000, 4, 0);
        run_txn(1, 32'h1002, 2, 0);

        // IF and MEM together: MEM first, IF accepted in the MEM done cycle
        if_addr = 32'h100; if_read = 1; mem_addr_to_read = 32'h2000; data_len = 3'd2; read_mem = 1;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk_in); #1;
            if (c == 1) read_mem = 0;
            if (c == 5) if_read = 0;
            @(negedge clk_in);
            chk("arb.mem_done", {31'd0, mem_load_done}, {31'd0, c == 4});
            chk("arb.if_done", {31'd0, if_done}, {31'd0, c == 10});
            chk("arb.busy", {30'd0, mem_ctrl_busy_state},
                (c <= 3) ? 32'd2 : (c >= 5 && c <= 9) ? 32'd1 : 32'd0);
            if (c == 4) chk("arb.read_in", mem_ctrl_read_in, 32'h00001280);
            if (c == 10) chk("arb.if_inst", if_inst, 32'h00000513);
        end
        @(posedge clk_in); #1;

        // Flush in cycle 3 of a fetch
        if_addr = 32'h180; if_read = 1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk_in); #1;
            if (c == 1) if_read = 0;
            if (c == 3) if_flush = 1;
            if (c == 4) if_flush = 0;
            @(negedge clk_in);
            chk("flush.if_done", {31'd0, if_done}, 32'd0);
            if (c == 3) chk("flush.busy3", {30'd0, mem_ctrl_busy_state}, 32'd1);
            if (c >= 4) begin
                chk("flush.busy", {30'd0, mem_ctrl_busy_state}, 32'd0);
                chk("flush.mem_a", mem_a, 32'd0);
            end
        end
        @(posedge clk_in); #1;
        preload(32'h200, 32'hA1B2C3D4, 4);
        run_txn(0, 32'h200, 4, 0);

        // Reset in cycle 2 of a 4-byte store
        mem_addr_to_read = 32'h1800; data_len = 3'd4; mem_data_to_write = 32'h11223344; write_mem = 1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk_in); #1;
            if (c == 1) write_mem = 0;
            if (c == 2) rst_in = 1;
            if (c == 3) rst_in = 0;
            @(negedge clk_in);
            if (c >= 3) begin
                check_idle_outs("rst_mid");
                chk("rst_mid.dout", {24'd0, mem_dout}, 32'd0);
            end
            if (c == 3) begin
                chk("rst_mid.if_inst", if_inst, 32'd0);
                chk("rst_mid.read_in", mem_ctrl_read_in, 32'd0);
            end
        end
        @(posedge clk_in); #1;

        for (int i = 0; i < 40; i++) begin
            int r, kind, n;
            r = $urandom_range(0, 9);
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 2))
                0: n = 1;
                1: n = 2;
                default: n = 4;
            endcase
            if (r == 0) try_reject(kind);
            else run_txn(kind, 32'h3000 + 32'($urandom_range(0, 255)), n, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
